// File: rtl/mdp3_price_book_if.sv
// Parser-to-book entry bus: one decoded MDP3 book entry with its valid level and qualifier.
// The parser drives the master side and the price book listens on the slave side.
interface mdp3_price_book_if;
    logic               message_ready;
    logic               enable_order_book;
    logic        [7:0]  ACTION;
    logic        [7:0]  ENTRY_TYPE;
    logic        [31:0] SECURITY_ID;
    logic signed [63:0] PRICE;
    logic        [31:0] QUANTITY;
    logic        [31:0] NUM_ORDERS;

    modport master (
        output message_ready, enable_order_book, ACTION, ENTRY_TYPE,
               SECURITY_ID, PRICE, QUANTITY, NUM_ORDERS
    );

    modport slave (
        input  message_ready, enable_order_book, ACTION, ENTRY_TYPE,
               SECURITY_ID, PRICE, QUANTITY, NUM_ORDERS
    );
endinterface

// File: rtl/mdp3_price_book.sv
// Price-sorted DEPTH-level bid/ask book for one security, fed by MDP3 parser entries.
// Optional MDP3_BOOK_STATS_EN adds saturating applied/dropped/miss counters.
module mdp3_price_book #(
    parameter int          DEPTH  = 5,
    parameter logic [31:0] SEC_ID = 32'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    mdp3_price_book_if.slave     entry,
    output logic [DEPTH*64-1:0]  bid_price,
    output logic [DEPTH*64-1:0]  ask_price,
    output logic [DEPTH*32-1:0]  bid_qty,
    output logic [DEPTH*32-1:0]  ask_qty,
    output logic [DEPTH*32-1:0]  bid_ord,
    output logic [DEPTH*32-1:0]  ask_ord,
    output logic [DEPTH-1:0]     bid_vld,
    output logic [DEPTH-1:0]     ask_vld,
`ifdef MDP3_BOOK_STATS_EN
    output logic [31:0]          stat_applied,
    output logic [31:0]          stat_dropped,
    output logic [31:0]          stat_miss,
`endif
    output logic                 book_updated,
    output logic                 busy,
    output logic                 overflow,
    output logic                 miss
);

    localparam int            IW        = $clog2(DEPTH + 1);
    localparam logic [IW-1:0] DEPTH_IDX = IW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_MATCH, S_APPLY} state_t;

    state_t             state_q, state_d;
    logic               mr_q, mr_d;
    logic [7:0]         act_q, act_d, type_q, type_d;
    logic [31:0]        sec_q, sec_d, qty_q, qty_d, ord_q, ord_d;
    logic signed [63:0] price_q, price_d;
    logic               side_q, side_d;
    logic [IW-1:0]      ins_q, ins_d, hit_q, hit_d;
    logic               hit_found_q, hit_found_d;

    logic signed [63:0] bid_price_q [DEPTH], bid_price_d [DEPTH];
    logic signed [63:0] ask_price_q [DEPTH], ask_price_d [DEPTH];
    logic [31:0]        bid_qty_q [DEPTH], bid_qty_d [DEPTH];
    logic [31:0]        ask_qty_q [DEPTH], ask_qty_d [DEPTH];
    logic [31:0]        bid_ord_q [DEPTH], bid_ord_d [DEPTH];
    logic [31:0]        ask_ord_q [DEPTH], ask_ord_d [DEPTH];
    logic [DEPTH-1:0]   bid_vld_q, bid_vld_d, ask_vld_q, ask_vld_d;
    logic               book_updated_q, book_updated_d;
    logic               miss_q, miss_d;
    logic               overflow_q, overflow_d;

    logic               take, reject, applied;
    logic signed [63:0] w_price [DEPTH], n_price [DEPTH];
    logic [31:0]        w_qty [DEPTH], n_qty [DEPTH];
    logic [31:0]        w_ord [DEPTH], n_ord [DEPTH];
    logic [DEPTH-1:0]   w_vld, n_vld, eq, better;
    logic [IW-1:0]      ins_c, hit_c;

    assign take   = entry.message_ready & ~mr_q & entry.enable_order_book;
    assign reject = (sec_q != SEC_ID) || (act_q > 8'd2) ||
                    ((type_q != 8'h30) && (type_q != 8'h31));

    // Selected side view plus parallel compare; bids rank high-first, asks low-first.
    always_comb begin
        w_vld = side_q ? ask_vld_q : bid_vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            w_price[i] = side_q ? ask_price_q[i] : bid_price_q[i];
            w_qty[i]   = side_q ? ask_qty_q[i]   : bid_qty_q[i];
            w_ord[i]   = side_q ? ask_ord_q[i]   : bid_ord_q[i];
            eq[i]      = w_vld[i] && (w_price[i] == price_q);
            better[i]  = !w_vld[i] ||
                         (side_q ? (price_q < w_price[i]) : (price_q > w_price[i]));
        end
        ins_c = DEPTH_IDX;
        hit_c = DEPTH_IDX;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (better[i]) ins_c = IW'(i);
            if (eq[i])     hit_c = IW'(i);
        end
    end

    always_comb begin
        state_d        = state_q;
        mr_d           = entry.message_ready;
        act_d          = act_q;
        type_d         = type_q;
        sec_d          = sec_q;
        price_d        = price_q;
        qty_d          = qty_q;
        ord_d          = ord_q;
        side_d         = side_q;
        ins_d          = ins_q;
        hit_d          = hit_q;
        hit_found_d    = hit_found_q;
        bid_price_d    = bid_price_q;
        ask_price_d    = ask_price_q;
        bid_qty_d      = bid_qty_q;
        ask_qty_d      = ask_qty_q;
        bid_ord_d      = bid_ord_q;
        ask_ord_d      = ask_ord_q;
        bid_vld_d      = bid_vld_q;
        ask_vld_d      = ask_vld_q;
        book_updated_d = 1'b0;
        miss_d         = 1'b0;
        overflow_d     = overflow_q;
        applied        = 1'b0;
        n_price        = w_price;
        n_qty          = w_qty;
        n_ord          = w_ord;
        n_vld          = w_vld;

        case (state_q)
            S_IDLE: begin
                if (take) begin
                    act_d   = entry.ACTION;
                    type_d  = entry.ENTRY_TYPE;
                    sec_d   = entry.SECURITY_ID;
                    price_d = entry.PRICE;
                    qty_d   = entry.QUANTITY;
                    ord_d   = entry.NUM_ORDERS;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (reject) begin
                    state_d = S_IDLE;
                end else begin
                    side_d  = (type_q == 8'h31);
                    state_d = S_MATCH;
                end
            end
            S_MATCH: begin
                ins_d       = ins_c;
                hit_d       = hit_c;
                hit_found_d = |eq;
                state_d     = S_APPLY;
            end
            S_APPLY: begin
                state_d = S_IDLE;
                if (hit_found_q && (act_q != 8'd2)) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (IW'(i) == hit_q) begin
                            n_qty[i] = qty_q;
                            n_ord[i] = ord_q;
                        end
                    end
                    applied = 1'b1;
                end else if (hit_found_q) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        if (IW'(i) >= hit_q) begin
                            n_price[i] = w_price[i+1];
                            n_qty[i]   = w_qty[i+1];
                            n_ord[i]   = w_ord[i+1];
                        end
                    end
                    n_price[DEPTH-1] = '0;
                    n_qty[DEPTH-1]   = '0;
                    n_ord[DEPTH-1]   = '0;
                    n_vld            = w_vld >> 1;
                    applied          = 1'b1;
                end else if (act_q != 8'd0) begin
                    miss_d = 1'b1;
                end else if (ins_q != DEPTH_IDX) begin
                    for (int i = 1; i < DEPTH; i++) begin
                        if (IW'(i) > ins_q) begin
                            n_price[i] = w_price[i-1];
                            n_qty[i]   = w_qty[i-1];
                            n_ord[i]   = w_ord[i-1];
                        end
                    end
                    for (int i = 0; i < DEPTH; i++) begin
                        if (IW'(i) == ins_q) begin
                            n_price[i] = price_q;
                            n_qty[i]   = qty_q;
                            n_ord[i]   = ord_q;
                        end
                    end
                    n_vld   = {w_vld[DEPTH-2:0], 1'b1};
                    applied = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take && (state_q != S_IDLE)) overflow_d = 1'b1;

        if (applied) begin
            book_updated_d = 1'b1;
            if (side_q) begin
                ask_price_d = n_price;
                ask_qty_d   = n_qty;
                ask_ord_d   = n_ord;
                ask_vld_d   = n_vld;
            end else begin
                bid_price_d = n_price;
                bid_qty_d   = n_qty;
                bid_ord_d   = n_ord;
                bid_vld_d   = n_vld;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            mr_q           <= 1'b0;
            act_q          <= '0;
            type_q         <= '0;
            sec_q          <= '0;
            price_q        <= '0;
            qty_q          <= '0;
            ord_q          <= '0;
            side_q         <= 1'b0;
            ins_q          <= '0;
            hit_q          <= '0;
            hit_found_q    <= 1'b0;
            bid_vld_q      <= '0;
            ask_vld_q      <= '0;
            book_updated_q <= 1'b0;
            miss_q         <= 1'b0;
            overflow_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bid_price_q[i] <= '0;
                ask_price_q[i] <= '0;
                bid_qty_q[i]   <= '0;
                ask_qty_q[i]   <= '0;
                bid_ord_q[i]   <= '0;
                ask_ord_q[i]   <= '0;
            end
        end else begin
            state_q        <= state_d;
            mr_q           <= mr_d;
            act_q          <= act_d;
            type_q         <= type_d;
            sec_q          <= sec_d;
            price_q        <= price_d;
            qty_q          <= qty_d;
            ord_q          <= ord_d;
            side_q         <= side_d;
            ins_q          <= ins_d;
            hit_q          <= hit_d;
            hit_found_q    <= hit_found_d;
            bid_vld_q      <= bid_vld_d;
            ask_vld_q      <= ask_vld_d;
            book_updated_q <= book_updated_d;
            miss_q         <= miss_d;
            overflow_q     <= overflow_d;
            bid_price_q    <= bid_price_d;
            ask_price_q    <= ask_price_d;
            bid_qty_q      <= bid_qty_d;
            ask_qty_q      <= ask_qty_d;
            bid_ord_q      <= bid_ord_d;
            ask_ord_q      <= ask_ord_d;
        end
    end

`ifdef MDP3_BOOK_STATS_EN
    logic [31:0] stat_applied_q, stat_applied_d;
    logic [31:0] stat_dropped_q, stat_dropped_d;
    logic [31:0] stat_miss_q, stat_miss_d;
    logic [1:0]  drop_inc;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {31'd0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // An overflow drop can coincide with a filter or full-side drop, hence a 2-bit step.
    always_comb begin
        drop_inc = 2'd0;
        if ((state_q == S_CAPTURE) && reject) drop_inc = drop_inc + 2'd1;
        if ((state_q == S_APPLY) && !hit_found_q && (act_q == 8'd0) && (ins_q == DEPTH_IDX))
            drop_inc = drop_inc + 2'd1;
        if (take && (state_q != S_IDLE)) drop_inc = drop_inc + 2'd1;
        stat_applied_d = sat_add(stat_applied_q, {1'b0, book_updated_d});
        stat_dropped_d = sat_add(stat_dropped_q, drop_inc);
        stat_miss_d    = sat_add(stat_miss_q, {1'b0, miss_d});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_applied_q <= '0;
            stat_dropped_q <= '0;
            stat_miss_q    <= '0;
        end else begin
            stat_applied_q <= stat_applied_d;
            stat_dropped_q <= stat_dropped_d;
            stat_miss_q    <= stat_miss_d;
        end
    end

    assign stat_applied = stat_applied_q;
    assign stat_dropped = stat_dropped_q;
    assign stat_miss    = stat_miss_q;
`endif

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            bid_price[64*i +: 64] = bid_price_q[i];
            ask_price[64*i +: 64] = ask_price_q[i];
            bid_qty[32*i +: 32]   = bid_qty_q[i];
            ask_qty[32*i +: 32]   = ask_qty_q[i];
            bid_ord[32*i +: 32]   = bid_ord_q[i];
            ask_ord[32*i +: 32]   = ask_ord_q[i];
        end
    end

    assign bid_vld      = bid_vld_q;
    assign ask_vld      = ask_vld_q;
    assign book_updated = book_updated_q;
    assign miss         = miss_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q != S_IDLE);

endmodule
